// File: rtl/mbscore_pkg.sv
// rtl/mbscore_pkg.sv - shared constants and types for the MBScore front end
package mbscore_pkg;

   localparam int          DATA_WIDTH = 32;
   localparam int          ADDR_WIDTH = 32;
   localparam logic [31:0] INST_NOP   = 32'h0000_0000;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/mbscore_inst_fifo.sv
// rtl/mbscore_inst_fifo.sv - synchronous instruction buffer with flush
// Flush wins over a same-cycle push or pop; DEPTH must be a power of two.
module mbscore_inst_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty && !i_flush;
   assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/mbscore_ifetch.sv
// rtl/mbscore_ifetch.sv - in-order instruction fetch with credit-limited requests
// Redirects flush the buffer; stale in-flight responses are dropped in FLUSH.
module mbscore_ifetch #(
   parameter int                    DATA_WIDTH = mbscore_pkg::DATA_WIDTH,
   parameter int                    ADDR_WIDTH = mbscore_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(mbscore_pkg::RESET_PC),
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc
);
   import mbscore_pkg::*;

   localparam int              CW       = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]     LP_DEPTH = (CW + 1)'(FIFO_DEPTH);

   fetch_state_e                     r_state;
   logic [ADDR_WIDTH-1:0]            r_pc;
   logic [ADDR_WIDTH-1:0]            r_rsp_pc;
   logic [CW-1:0]                    r_outstanding;
   logic [CW-1:0]                    w_out_next;
   logic [CW-1:0]                    w_fifo_count;
   logic [CW:0]                      w_used;
   logic                             w_fifo_empty;
   logic                             w_fifo_full;
   logic                             w_req_fire;
   logic                             w_push;
   logic                             w_pop;
   logic [ADDR_WIDTH-1:0]            w_redirect_pc;
   logic [DATA_WIDTH+ADDR_WIDTH-1:0] w_fifo_rdata;

   // Requests in flight plus buffered words never exceed the buffer depth.
   assign w_used         = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
   assign imem_req_valid = !rst && (r_state == ST_RUN) && !redirect_valid && (w_used < LP_DEPTH);
   assign imem_req_addr  = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   assign w_out_next     = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
   assign w_redirect_pc  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

   assign w_push     = (r_state == ST_RUN) && !redirect_valid && imem_rsp_valid;
   assign inst_valid = (r_state == ST_RUN) && !redirect_valid && !w_fifo_empty;
   assign w_pop      = inst_valid && inst_ready;
   assign inst       = inst_valid ? w_fifo_rdata[DATA_WIDTH-1:0] : DATA_WIDTH'(INST_NOP);
   assign inst_pc    = inst_valid ? w_fifo_rdata[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH] : '0;

   // r_rsp_pc tracks the address of the oldest live request, so responses carry their PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_pc          <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_outstanding <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (redirect_valid) begin
            r_pc     <= w_redirect_pc;
            r_rsp_pc <= w_redirect_pc;
            r_state  <= (w_out_next != '0) ? ST_FLUSH : ST_RUN;
         end else begin
            if (w_req_fire) r_pc     <= r_pc + ADDR_WIDTH'(4);
            if (w_push)     r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(4);
            if ((r_state == ST_FLUSH) && (w_out_next == '0)) r_state <= ST_RUN;
         end
      end
   end

   mbscore_inst_fifo #(
      .WIDTH (DATA_WIDTH + ADDR_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata ({r_rsp_pc, imem_rsp_data}),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_rdata (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   always @(posedge clk) begin
      if (!rst) begin
         a_no_underflow: assert (!(imem_rsp_valid && (r_outstanding == '0)));
         a_no_overflow:  assert (!(w_push && w_fifo_full));
      end
   end

endmodule

// File: tb/tb_mbscore_ifetch.sv
// tb/tb_mbscore_ifetch.sv - scoreboard and vector bench for mbscore_ifetch
module tb_mbscore_ifetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;

   mbscore_ifetch #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } mem_ent_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } exp_ent_t;
   typedef struct { logic [31:0] rpc; logic [31:0] exp_a0; logic [31:0] exp_a1; } redir_vec_t;

   mem_ent_t    mem_q[$];
   exp_ent_t    sb[$];
   int          cyc, lat, stale, n_checks, n_fail;
   logic [31:0] exp_pc;
   logic        rdy, mrdy;
   logic        last_fire, last_hs, last_iv;
   logic [31:0] last_fire_addr, last_hs_pc;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'h0021_0820 + a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive at negedge, compare 1 time unit later, advance model, next negedge.
   task automatic cycle(input logic redir, input logic [31:0] rpc);
      logic     present, exp_req, exp_iv;
      mem_ent_t m;
      exp_ent_t e;
      present = (mem_q.size() > 0) && (mem_q[0].due == cyc);
      redirect_valid = redir;
      redirect_pc    = rpc;
      inst_ready     = rdy;
      imem_req_ready = mrdy;
      imem_rsp_valid = present;
      imem_rsp_data  = present ? mem_data(mem_q[0].addr) : 32'h0;
      #1;
      exp_req = !redir && (stale == 0) && ((mem_q.size() + sb.size()) < DEPTH);
      exp_iv  = !redir && (sb.size() > 0);
      check("req_valid", imem_req_valid, exp_req);
      if (exp_req) check("req_addr", imem_req_addr, exp_pc);
      check("inst_valid", inst_valid, exp_iv);
      if (exp_iv) begin
         check("inst", inst, sb[0].data);
         check("inst_pc", inst_pc, sb[0].pc);
      end else begin
         check("inst_idle", inst, 32'h0);
         check("inst_pc_idle", inst_pc, 32'h0);
      end
      last_iv        = inst_valid;
      last_fire      = imem_req_valid && imem_req_ready;
      last_fire_addr = imem_req_addr;
      last_hs        = inst_valid && inst_ready;
      last_hs_pc     = inst_pc;
      if (present && !redir) begin
         if (stale > 0) stale--;
         else begin
            e.pc   = mem_q[0].addr;
            e.data = mem_data(mem_q[0].addr);
            sb.push_back(e);
         end
      end
      if (exp_iv && rdy) sb.delete(0);
      if (present) mem_q.delete(0);
      if (redir) begin
         sb.delete();
         stale  = mem_q.size();
         exp_pc = {rpc[31:2], 2'b00};
      end else if (last_fire) begin
         exp_pc = exp_pc + 32'd4;
      end
      if (last_fire) begin
         m.addr = imem_req_addr;
         m.due  = cyc + lat;
         mem_q.push_back(m);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      inst_ready = 1'b0; imem_req_ready = 1'b1;
      mem_q.delete(); sb.delete();
      stale = 0; exp_pc = 32'h0; cyc = 0;
      @(negedge clk);
      #1;
      check("rst_req_valid", imem_req_valid, 32'h0);
      check("rst_inst_valid", inst_valid, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_inst_pc", inst_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_fire(input string name, output logic [31:0] addr, output int n);
      n = 0;
      do begin
         cycle(1'b0, 32'h0);
         n++;
      end while (!last_fire && n < 50);
      if (!last_fire) begin
         n_checks++; n_fail++;
         $display("FAIL %s: got no request in 50 cycles, expected one", name);
      end
      addr = last_fire_addr;
   endtask

   task automatic wait_hs(input string name, output logic [31:0] pc);
      int n = 0;
      do begin
         cycle(1'b0, 32'h0);
         n++;
      end while (!last_hs && n < 50);
      if (!last_hs) begin
         n_checks++; n_fail++;
         $display("FAIL %s: got no instruction in 50 cycles, expected one", name);
      end
      pc = last_hs_pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
      $fatal(1);
   end

   initial begin
      redir_vec_t  vecs[4];
      logic [31:0] t1_addr[6];
      logic        t1_iv[6];
      logic [31:0] t1_pc[6];
      logic [31:0] a, ff;
      logic [31:0] hs_q[$];
      int          n, fires;
      logic        have;

      vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
      vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[3] = '{32'h8000_0006, 32'h8000_0004, 32'h8000_0008};
      t1_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      t1_iv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      t1_pc   = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};

      n_checks = 0; n_fail = 0; lat = 1; rdy = 1'b1; mrdy = 1'b1;

      // Streaming start-up with a 1-cycle memory
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 32'h0);
         check("t1_fire", last_fire, 32'h1);
         check("t1_addr", last_fire_addr, t1_addr[i]);
         check("t1_inst_valid", last_iv, 32'(t1_iv[i]));
         if (t1_iv[i]) check("t1_inst_pc", last_hs_pc, t1_pc[i]);
      end

      // Decode stalled: credit stops at the buffer depth, then drains in order
      do_reset();
      rdy = 1'b0; fires = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 32'h0);
         if (last_fire) fires++;
      end
      check("t2_fire_count", 32'(fires), 32'd4);
      rdy = 1'b1; have = 1'b0; ff = 32'hFFFF_FFFF; hs_q.delete();
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 32'h0);
         if (last_hs) hs_q.push_back(last_hs_pc);
         if (last_fire && !have) begin have = 1'b1; ff = last_fire_addr; end
      end
      check("t2_resume_addr", ff, 32'h10);
      for (int i = 0; i < 4; i++)
         check("t2_drain_pc", (hs_q.size() > i) ? hs_q[i] : 32'hDEAD_DEAD, 32'(i * 4));

      // 3-cycle memory, three in flight, redirect while the oldest returns
      do_reset();
      lat = 3;
      repeat (3) cycle(1'b0, 32'h0);
      cycle(1'b1, 32'h0000_0103);
      check("t3_redirect_hs", last_hs, 32'h0);
      wait_fire("t3_fire", a, n);
      check("t3_fire_addr", a, 32'h100);
      check("t3_flush_cycles", 32'(n), 32'd3);
      wait_hs("t3_hs", a);
      check("t3_first_pc", a, 32'h100);

      // Redirect vectors in a streaming pipe, including address wrap
      do_reset();
      lat = 1;
      for (int v = 0; v < 4; v++) begin
         repeat (4) cycle(1'b0, 32'h0);
         cycle(1'b1, vecs[v].rpc);
         check("tv_redirect_hs", last_hs, 32'h0);
         wait_fire("tv_fire0", a, n);
         check("tv_addr0", a, vecs[v].exp_a0);
         check("tv_wait0", 32'(n), 32'd1);
         wait_fire("tv_fire1", a, n);
         check("tv_addr1", a, vecs[v].exp_a1);
      end

      // Asynchronous reset with the buffer half full
      do_reset();
      rdy = 1'b0;
      repeat (3) cycle(1'b0, 32'h0);
      imem_rsp_valid = 1'b0;
      #1;
      check("t6_pre_inst_valid", inst_valid, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_req_valid", imem_req_valid, 32'h0);
      check("t6_async_inst_valid", inst_valid, 32'h0);
      check("t6_async_inst", inst, 32'h0);
      check("t6_async_inst_pc", inst_pc, 32'h0);
      do_reset();
      rdy = 1'b1;
      wait_fire("t6_fire", a, n);
      check("t6_first_addr", a, 32'h0);
      check("t6_first_wait", 32'(n), 32'd1);

      // Random backpressure and redirects against the scoreboard
      do_reset();
      lat = 2;
      for (int i = 0; i < 400; i++) begin
         rdy  = ($urandom_range(0, 3) != 0);
         mrdy = ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 24) == 0), $urandom);
      end
      mrdy = 1'b1; rdy = 1'b1;
      repeat (10) cycle(1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
